fifo_unpacker: RTL and testbench
================================

// Module: fifo_unpacker
// PURPOSE
//  Downstream consumer of the team FIFO (fifo_cl). Pops one IN_WIDTH word and emits it
//  as RATIO = IN_WIDTH/OUT_WIDTH chunks on a valid/ready stream, e.g. 32-bit to 8-bit for a byte sink.
//  Drives the FIFO's level-sensitive drop with exactly one single-cycle pulse per word.
// PARAMETERS
//  IN_WIDTH   32  FIFO word width. Must be an integer multiple of OUT_WIDTH.
//  OUT_WIDTH  8   Output chunk width. RATIO = IN_WIDTH/OUT_WIDTH, RATIO >= 1.
//  LSB_FIRST  1   1: emit chunk [OUT_WIDTH-1:0] first. 0: emit the MS chunk first.
// PORTS
//  clk         in   1          Clock, posedge.
//  rst         in   1          Synchronous reset, active-high.
//  fifo_empty  in   1          FIFO empty flag.
//  fifo_data   in   IN_WIDTH   FIFO data_o (head entry, combinational).
//  fifo_drop   out  1          Pop request to FIFO drop. Single-cycle pulse.
//  out_data    out  OUT_WIDTH  Current chunk.
//  out_valid   out  1          out_data is valid.
//  out_ready   in   1          Sink accepts the chunk when out_valid & out_ready.
//  out_last    out  1          Current chunk is the final chunk of its word.
//  busy        out  1          Word held: 1 in SEND state.
// BEHAVIOUR
//  - Reset: state=IDLE, fifo_drop=0, out_valid=0, out_last=0, busy=0, out_data=0,
//    shift reg=0, chunk_cnt=0. rst overrides everything, including mid-word.
//    The partial word is discarded. No drop is issued in the reset cycle.
//  - State IDLE: if ~fifo_empty, then at the edge:
//    - capture fifo_data into the shift reg,
//    - assert fifo_drop for that next cycle only,
//    - chunk_cnt=0,
//    - go to SEND.
//    Otherwise stay in IDLE.
//  - State SEND: out_valid=1.
//    - out_data = chunk chunk_cnt (LSB_FIRST) or chunk RATIO-1-chunk_cnt.
//    - out_last = (chunk_cnt == RATIO-1).
//  - Handshake:
//    - A transfer occurs on a cycle with out_valid & out_ready.
//    - out_data and out_valid hold stable while out_ready=0. No chunk is ever skipped or repeated.
//    - Transfer with chunk_cnt < RATIO-1: chunk_cnt++.
//  - Transfer on the last chunk:
//    - if ~fifo_empty: load the next word, pulse fifo_drop, chunk_cnt=0, stay in SEND.
//      Back-to-back operation, no bubble.
//    - else: go to IDLE, out_valid=0 next cycle.
//  - Drop safety:
//    - fifo_drop is registered and asserted only in the cycle after a load.
//    - The next load is at least one cycle later, by which point fifo_empty and fifo_data
//      already reflect the pop.
//    - With RATIO=1, consecutive words still need one cycle each. The minimum is 1 word per cycle.
//  - Latency: FIFO non-empty at an edge in IDLE -> out_valid=1 after that edge (1 cycle).
//  - Throughput: 1 chunk/cycle while out_ready=1 and the FIFO is non-empty.
//  - fifo_drop is never asserted while fifo_empty was 1 at the loading edge.
//    Each popped word yields exactly RATIO transfers.
//  - Width: chunk_cnt is $clog2(RATIO) bits, minimum 1. It wraps only via an explicit reset to 0.
// TESTING
//  1. Reset then idle: fifo_empty=1 for 10 cycles -> out_valid=0, fifo_drop=0 throughout.
//  2. Single word, IN=32, OUT=8, LSB_FIRST=1, word 0xA1B2C3D4, out_ready=1:
//     - chunks 0xD4, 0xC3, 0xB2, 0xA1,
//     - out_last only on 0xA1,
//     - exactly one fifo_drop pulse.
//  3. Same word with LSB_FIRST=0 and out_ready toggling 1,0,1,0:
//     - chunks 0xA1, 0xB2, 0xC3, 0xD4,
//     - each chunk held stable while ready=0.
//  4. Back-to-back: FIFO preloaded with 3 words, out_ready=1:
//     - 12 consecutive transfers with no bubble,
//     - 3 drop pulses, each 1 cycle, spaced 4 cycles,
//     - FIFO awaiting_count reaches 0.
//  5. RATIO=1 (IN=OUT=8), 5 words queued:
//     - 5 transfers in 5 consecutive cycles, data in order,
//     - no extra drop, out_last=1 on every transfer.
//  6. Reset mid-word, asserted after the 2nd chunk:
//     - next cycle out_valid=0 and busy=0,
//     - after rst deasserts, the next FIFO word starts from chunk 0.

Source files
------------

// File: rtl/fifo_unpacker_if.sv
// fifo_unpacker bus: FIFO pop side plus chunked valid/ready stream.
// master = unpacker (drives drop, out_*, busy); slave = FIFO + sink.
interface fifo_unpacker_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
);
  logic                 fifo_empty;
  logic [IN_WIDTH-1:0]  fifo_data;
  logic                 fifo_drop;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 busy;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  out_ready,
    output fifo_drop,
    output out_data,
    output out_valid,
    output out_last,
    output busy
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output out_ready,
    input  fifo_drop,
    input  out_data,
    input  out_valid,
    input  out_last,
    input  busy
  );
endinterface

// File: rtl/fifo_unpacker.sv
// fifo_unpacker: pops IN_WIDTH words, streams RATIO OUT_WIDTH chunks.
// Ports: clk, rst (sync, active-high), bus (fifo_unpacker_if.master).
module fifo_unpacker #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             rst,
  fifo_unpacker_if.master bus
);
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                         state_q, state_d;
  logic [IN_WIDTH-1:0]            sreg_q, sreg_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           drop_q, drop_d;
  logic [RATIO-1:0][OUT_WIDTH-1:0] chunks;
  logic [CW-1:0]                  idx;
  logic                           send;
  logic                           last;
  logic                           xfer;
  logic                           load;
  logic                           adv;
  logic                           fin;

  assign chunks = sreg_q;
  assign send   = (state_q == SEND);
  assign last   = (cnt_q == LAST_IDX);
  assign xfer   = send & bus.out_ready;
  assign idx    = LSB_FIRST ? cnt_q
                            : LAST_IDX - cnt_q;

  // load, adv and fin are mutually exclusive
  assign load = ~bus.fifo_empty &
                (~send | (xfer & last));
  assign adv  = xfer & ~last;
  assign fin  = xfer & last & bus.fifo_empty;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    unique case (1'b1)
      load: begin
        state_d = SEND;
        sreg_d  = bus.fifo_data;
        cnt_d   = '0;
        drop_d  = 1'b1;
      end
      adv: begin
        cnt_d = cnt_q + 1'b1;
      end
      fin: begin
        state_d = IDLE;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.fifo_drop = drop_q;
  assign bus.out_valid = send;
  assign bus.busy      = send;
  assign bus.out_last  = send & last;
  assign bus.out_data  = send ? chunks[idx]
                              : '0;
endmodule

// File: tb/tb_fifo_unpacker.sv
// Bench for fifo_unpacker: 32->8 LSB, 32->8 MSB, 8->8.
// FIFO models pop mid-cycle while drop is high.
module tb_fifo_unpacker;
  typedef enum int {
    K_RST, K_CLR, K_DROPS, K_RUN,
    K_GAPS, K_AWAIT, K_SBE, K_TMO
  } kind_t;

  typedef struct packed {
    kind_t k;
    int    i;
    int    e;
  } chk_t;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_unpacker_if #(32, 8) ia();
  fifo_unpacker_if #(32, 8) ib();
  fifo_unpacker_if #(8, 8)  ic();

  fifo_unpacker #(
    .IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b1)
  ) u_a (.clk(clk), .rst(rst), .bus(ia));

  fifo_unpacker #(
    .IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b0)
  ) u_b (.clk(clk), .rst(rst), .bus(ib));

  fifo_unpacker #(
    .IN_WIDTH(8), .OUT_WIDTH(8), .LSB_FIRST(1'b1)
  ) u_c (.clk(clk), .rst(rst), .bus(ic));

  logic [31:0] mem [3][32];
  int   wp [3] = '{0, 0, 0};
  int   rp [3] = '{0, 0, 0};
  logic [31:0] hc;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];
  chk_t chk_q[$];

  int n_cmp = 0;
  int n_err = 0;

  assign ia.fifo_empty = (wp[0] == rp[0]);
  assign ib.fifo_empty = (wp[1] == rp[1]);
  assign ic.fifo_empty = (wp[2] == rp[2]);
  assign ia.fifo_data  = mem[0][rp[0] % 32];
  assign ib.fifo_data  = mem[1][rp[1] % 32];
  assign hc            = mem[2][rp[2] % 32];
  assign ic.fifo_data  = hc[7:0];

  function automatic int sbsize(int i);
    case (i)
      0: return sb0.size();
      1: return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  function automatic exp_t sbpop(int i);
    exp_t e;
    case (i)
      0: e = sb0.pop_front();
      1: e = sb1.pop_front();
      default: e = sb2.pop_front();
    endcase
    return e;
  endfunction

  task automatic chk(string nm, int i,
                     logic [31:0] act,
                     logic [31:0] ex);
    n_cmp++;
    if (act !== ex) begin
      n_err++;
      $display("FAIL %s inst%0d got=%0h want=%0h",
               nm, i, act, ex);
    end
  endtask

  // monitor / scoreboard / FIFO pop model
  initial begin : mon
    logic       v [3];
    logic       r [3];
    logic       l [3];
    logic       dr [3];
    logic       bz [3];
    logic [7:0] d [3];
    logic       hold [3];
    logic [7:0] hd [3];
    logic       hl [3];
    logic       dprev [3];
    int         run [3];
    int         mrun [3];
    int         drops [3];
    int         ldc [3];
    int         gmin [3];
    int         gmax [3];
    int         cyc;
    exp_t       e;
    chk_t       c;
    logic [4:0] s;
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      hold[i] = 1'b0; dprev[i] = 1'b0;
      hd[i] = '0; hl[i] = 1'b0;
      run[i] = 0; mrun[i] = 0; drops[i] = 0;
      ldc[i] = -1; gmin[i] = 1000000; gmax[i] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      v[0] = ia.out_valid; v[1] = ib.out_valid;
      v[2] = ic.out_valid;
      r[0] = ia.out_ready; r[1] = ib.out_ready;
      r[2] = ic.out_ready;
      l[0] = ia.out_last; l[1] = ib.out_last;
      l[2] = ic.out_last;
      dr[0] = ia.fifo_drop; dr[1] = ib.fifo_drop;
      dr[2] = ic.fifo_drop;
      bz[0] = ia.busy; bz[1] = ib.busy;
      bz[2] = ic.busy;
      d[0] = ia.out_data; d[1] = ib.out_data;
      d[2] = ic.out_data;
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        case (c.k)
          K_RST: begin
            s = {v[c.i], dr[c.i], bz[c.i],
                 l[c.i], |d[c.i]};
            chk("rst_state", c.i, 32'(s), 32'd0);
          end
          K_CLR: begin
            for (int i = 0; i < 3; i++) begin
              mrun[i] = 0; drops[i] = 0; ldc[i] = -1;
              gmin[i] = 1000000; gmax[i] = 0;
            end
          end
          K_DROPS: chk("drops", c.i, drops[c.i], c.e);
          K_RUN:   chk("run", c.i, mrun[c.i], c.e);
          K_GAPS: begin
            chk("gap_min", c.i, gmin[c.i], c.e);
            chk("gap_max", c.i, gmax[c.i], c.e);
          end
          K_AWAIT: chk("await", c.i,
                       wp[c.i] - rp[c.i], c.e);
          K_SBE:   chk("sb_empty", c.i,
                       sbsize(c.i), 0);
          default: begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout inst%0d got=busy want=done_in_%0d",
                     c.i, c.e);
          end
        endcase
      end
      for (int i = 0; i < 3; i++) begin
        if (hold[i])
          chk("hold", i, 32'({v[i], l[i], d[i]}),
              32'({1'b1, hl[i], hd[i]}));
        hold[i] = v[i] && !r[i] && !rst;
        hd[i] = d[i];
        hl[i] = l[i];
        if (v[i] && r[i]) begin
          if (sbsize(i) == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_chunk inst%0d got=%0h want=none",
                     i, d[i]);
          end else begin
            e = sbpop(i);
            chk("chunk", i, 32'({d[i], l[i]}),
                32'({e.d, e.l}));
          end
          run[i]++;
          if (run[i] > mrun[i]) mrun[i] = run[i];
        end else begin
          run[i] = 0;
        end
        if (dr[i]) begin
          drops[i]++;
          if (i < 2)
            chk("drop_width", i, 32'(dprev[i]), 32'd0);
          if (!dprev[i] || i == 2) begin
            if (ldc[i] >= 0) begin
              if (cyc - ldc[i] < gmin[i])
                gmin[i] = cyc - ldc[i];
              if (cyc - ldc[i] > gmax[i])
                gmax[i] = cyc - ldc[i];
            end
            ldc[i] = cyc;
          end
          chk("pop_nonempty", i,
              32'(wp[i] != rp[i]), 32'd1);
          if (wp[i] != rp[i]) rp[i]++;
        end
        dprev[i] = dr[i];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(kind_t k, int i, int e);
    chk_t c;
    c.k = k; c.i = i; c.e = e;
    chk_q.push_back(c);
  endtask

  task automatic ex(int i, logic [7:0] d, logic l);
    exp_t e;
    e.d = d; e.l = l;
    case (i)
      0: sb0.push_back(e);
      1: sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  task automatic push_word(int i, logic [31:0] w);
    mem[i][wp[i] % 32] = w;
    wp[i]++;
  endtask

  task automatic wait_sb(int i, int budget);
    int n;
    n = 0;
    while (sbsize(i) != 0 && n < budget) begin
      step();
      n++;
    end
    if (sbsize(i) != 0) req(K_TMO, i, budget);
    step();
    step();
  endtask

  logic [7:0] t4 [12] = '{
    8'h44, 8'h33, 8'h22, 8'h11,
    8'h88, 8'h77, 8'h66, 8'h55,
    8'hEF, 8'hBE, 8'hAD, 8'hDE
  };

  initial begin : stim
    ia.out_ready = 1'b0;
    ib.out_ready = 1'b0;
    ic.out_ready = 1'b0;
    step();
    for (int j = 0; j < 3; j++) req(K_RST, j, 0);
    step();
    step();
    rst = 1'b0;
    // idle with empty FIFOs
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 3; j++) req(K_RST, j, 0);
      step();
    end
    // single word, LSB first
    req(K_CLR, 0, 0);
    ia.out_ready = 1'b1;
    ex(0, 8'hD4, 1'b0); ex(0, 8'hC3, 1'b0);
    ex(0, 8'hB2, 1'b0); ex(0, 8'hA1, 1'b1);
    push_word(0, 32'hA1B2C3D4);
    wait_sb(0, 20);
    req(K_DROPS, 0, 1);
    req(K_AWAIT, 0, 0);
    step();
    // single word, MS first, ready toggling
    req(K_CLR, 1, 0);
    ib.out_ready = 1'b1;
    ex(1, 8'hA1, 1'b0); ex(1, 8'hB2, 1'b0);
    ex(1, 8'hC3, 1'b0); ex(1, 8'hD4, 1'b1);
    push_word(1, 32'hA1B2C3D4);
    for (int k = 0; k < 40 && sbsize(1) != 0; k++) begin
      step();
      ib.out_ready = ~ib.out_ready;
    end
    ib.out_ready = 1'b1;
    wait_sb(1, 20);
    req(K_DROPS, 1, 1);
    step();
    // back-to-back, three preloaded words
    req(K_CLR, 0, 0);
    for (int k = 0; k < 12; k++)
      ex(0, t4[k], (k % 4) == 3);
    push_word(0, 32'h11223344);
    push_word(0, 32'h55667788);
    push_word(0, 32'hDEADBEEF);
    wait_sb(0, 40);
    req(K_DROPS, 0, 3);
    req(K_RUN, 0, 12);
    req(K_GAPS, 0, 4);
    req(K_AWAIT, 0, 0);
    step();
    // RATIO=1, five words
    req(K_CLR, 2, 0);
    ic.out_ready = 1'b1;
    ex(2, 8'h11, 1'b1); ex(2, 8'h22, 1'b1);
    ex(2, 8'h33, 1'b1); ex(2, 8'h44, 1'b1);
    ex(2, 8'h55, 1'b1);
    push_word(2, 32'h11); push_word(2, 32'h22);
    push_word(2, 32'h33); push_word(2, 32'h44);
    push_word(2, 32'h55);
    wait_sb(2, 30);
    req(K_DROPS, 2, 5);
    req(K_RUN, 2, 5);
    req(K_AWAIT, 2, 0);
    step();
    // reset after the second chunk
    req(K_CLR, 0, 0);
    ia.out_ready = 1'b1;
    ex(0, 8'h04, 1'b0); ex(0, 8'h03, 1'b0);
    push_word(0, 32'h01020304);
    step();
    step();
    step();
    ia.out_ready = 1'b0;
    rst = 1'b1;
    step();
    for (int j = 0; j < 3; j++) req(K_RST, j, 0);
    rst = 1'b0;
    step();
    ia.out_ready = 1'b1;
    ex(0, 8'h0D, 1'b0); ex(0, 8'h0C, 1'b0);
    ex(0, 8'h0B, 1'b0); ex(0, 8'h0A, 1'b1);
    push_word(0, 32'h0A0B0C0D);
    wait_sb(0, 20);
    req(K_DROPS, 0, 2);
    for (int j = 0; j < 3; j++) begin
      req(K_SBE, j, 0);
      req(K_AWAIT, j, 0);
    end
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
